stopwatch_timer_ctrl: RTL and testbench
=======================================

Name: stopwatch_timer_ctrl

Overview:
Parametrised stopwatch/timer controller: run-control FSM plus integrated prescaler, up/down counter, lap capture and countdown expiry. Next generation of the IDLE/RUNNING/PAUSED control block. Drives the display datapath directly with a count value instead of only a count-enable. Single clock domain; all outputs registered.

Parameters:
CNT_W, 16, width of count, load_val and lap_val.
PRESCALE, 1000, clk cycles per count step; legal range 1..2^20. Prescaler width is derived internally.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
start  in  1  level; run/resume request.
stop  in  1  level; pause request.
clear  in  1  synchronous clear to IDLE; highest priority after rst.
lap  in  1  capture the current count into lap_val.
mode  in  1  0 = count up, 1 = count down. Sampled only on IDLE->RUNNING.
load_val  in  CNT_W  countdown start value. Sampled with mode.
count  out  CNT_W  current count.
lap_val  out  CNT_W  last captured count.
status  out  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 DONE.
count_en  out  1  high iff status == RUNNING.
done  out  1  one-cycle pulse on countdown expiry.
wrap  out  1  one-cycle pulse on up-count wrap from all-ones to 0.

Behaviour:
- Reset (rst=1, async): state IDLE, count 0, prescaler 0, lap_val 0, mode_q 0, done 0, wrap 0, count_en 0, status 00.
- status and count_en are registered and change on the same edge as the state.
- clear=1 at an edge: state IDLE, count 0, prescaler 0, lap_val 0, no pulses. Overrides start/stop/lap/tick in that cycle.
- Transitions, evaluated when clear=0:
  - IDLE, start=1: mode_q<=mode, prescaler<=0, go RUNNING. count<=0 if mode=0, count<=load_val if mode=1.
  - IDLE, start=1, mode=1, load_val==0: go DONE directly, done pulses, count stays 0.
  - RUNNING, stop=1: go PAUSED. stop wins if start is also high.
  - PAUSED, start=1 and stop=0: go RUNNING. No reload. Prescaler phase is preserved.
  - DONE, start=1: reload load_val, take mode from mode_q, prescaler 0, go RUNNING (restart). Same zero-value rule as IDLE applies.
  - All other input combinations: hold state. start in RUNNING is ignored.
- Prescaler advances only while state==RUNNING. It is held in PAUSED/DONE and zeroed in IDLE.
- Tick: state==RUNNING and prescaler==PRESCALE-1. On a tick, prescaler<=0 and count steps.
  - First step occurs PRESCALE edges after the edge that entered RUNNING.
  - PRESCALE=1 gives a step every cycle.
- A tick in the same cycle as stop still applies; the pause takes effect afterwards.
- Up mode (mode_q=0): count+1 modulo 2^CNT_W. Step from all-ones gives count=0 and wrap=1 for one cycle. No state change.
- Down mode (mode_q=1): count-1. Step from 1 gives count=0, state DONE, done=1 for one cycle. count holds 0 in DONE.
- lap=1 in RUNNING or PAUSED: lap_val<=count as it is before any same-cycle step. lap is ignored in IDLE and DONE.
- done and wrap are never high in consecutive cycles except when caused by consecutive distinct events.
- Undefined state encodings cannot occur: 2-bit state, all four encodings used.

Test Plan:
1. Bench uses CNT_W=8, PRESCALE=4. rst pulse, then start=1 mode=0 for 1 cycle -> status=01 next edge; count 1,2,3 at +4,+8,+12 cycles; count_en=1 throughout.
2. Run up from 0 for 256 ticks -> count 255 then 0; wrap high exactly on the 0 edge, one cycle; status stays 01.
3. mode=1 load_val=3, start -> count 3,2,1,0 every 4 cycles. On 0: status=11, done=1 for one cycle, count_en=0. start again -> count=3, status=01.
4. Running, stop at prescaler=2 held 10 cycles, then start -> status 10 then 01; count unchanged while paused; next step 2 cycles after resume.
5. start and stop asserted together in RUNNING -> PAUSED. clear together with start in PAUSED -> IDLE, count=0, lap_val=0.
6. lap at count=5 during RUNNING -> lap_val=5. lap in IDLE -> lap_val unchanged. rst asserted mid-run, asynchronously without a clock edge -> all outputs at reset values.

Source files
------------

// File: rtl/stopwatch_timer_ctrl.sv
// Stopwatch/timer controller: run-control FSM with an integrated prescaler,
// an up/down counter, lap capture and countdown expiry. All outputs are registered.
module stopwatch_timer_ctrl #(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  input  logic             mode,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] lap_val,
  output logic [1:0]       status,
  output logic             count_en,
  output logic             done,
  output logic             wrap
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    DONE    = 2'b11
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] lap_q;
  logic [PS_W-1:0]  presc_q;
  logic             mode_q;
  logic             count_en_q;
  logic             done_q;
  logic             wrap_q;

  logic             tick;
  logic [CNT_W-1:0] step_d;
  logic             run_mode_d;
  logic             start_zero_d;

  // A restart from DONE reuses the latched direction; a fresh start samples mode.
  always_comb begin
    tick         = (state_q == RUNNING) && (presc_q == PS_LAST);
    step_d       = mode_q ? (count_q - CNT_ONE) : (count_q + CNT_ONE);
    run_mode_d   = (state_q == IDLE) ? mode : mode_q;
    start_zero_d = run_mode_d && (load_val == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      lap_q      <= '0;
      presc_q    <= '0;
      mode_q     <= 1'b0;
      count_en_q <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (clear) begin
        state_q    <= IDLE;
        count_q    <= '0;
        lap_q      <= '0;
        presc_q    <= '0;
        count_en_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start) begin
              mode_q  <= run_mode_d;
              presc_q <= '0;
              if (start_zero_d) begin
                state_q    <= DONE;
                count_q    <= '0;
                done_q     <= 1'b1;
                count_en_q <= 1'b0;
              end else begin
                state_q    <= RUNNING;
                count_q    <= run_mode_d ? load_val : '0;
                count_en_q <= 1'b1;
              end
            end
          end
          RUNNING: begin
            if (lap) lap_q <= count_q;
            if (tick) begin
              presc_q <= '0;
              count_q <= step_d;
              if (!mode_q && (count_q == '1)) wrap_q <= 1'b1;
            end else begin
              presc_q <= presc_q + PS_ONE;
            end
            // Expiry takes precedence over a simultaneous pause request.
            if (tick && mode_q && (count_q == CNT_ONE)) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              count_en_q <= 1'b0;
            end else if (stop) begin
              state_q    <= PAUSED;
              count_en_q <= 1'b0;
            end
          end
          PAUSED: begin
            if (lap) lap_q <= count_q;
            if (start && !stop) begin
              state_q    <= RUNNING;
              count_en_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign count    = count_q;
  assign lap_val  = lap_q;
  assign status   = state_q;
  assign count_en = count_en_q;
  assign done     = done_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Scoreboard bench for stopwatch_timer_ctrl (CNT_W=8, PRESCALE=4): directed stimulus
// pushes hand-computed expectations tagged with a cycle number; a monitor pops and checks them.
module tb_stopwatch_timer_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       clear;
  logic       lap;
  logic       mode;
  logic [7:0] loadVal;
  logic [7:0] count;
  logic [7:0] lapVal;
  logic [1:0] status;
  logic       countEn;
  logic       done;
  logic       wrap;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] cnt;
    logic [7:0] lapv;
    logic [1:0] st;
    logic       dn;
    logic       wr;
  } exp_t;

  exp_t sb[$];

  stopwatch_timer_ctrl #(
    .CNT_W    (8),
    .PRESCALE (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .lap      (lap),
    .mode     (mode),
    .load_val (loadVal),
    .count    (count),
    .lap_val  (lapVal),
    .status   (status),
    .count_en (countEn),
    .done     (done),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // count_en must always track RUNNING, so it is checked against the expected status.
  task automatic checkOutput(input exp_t e);
    logic wantCe;
    wantCe = (e.st == 2'b01);
    vectors++;
    if (count !== e.cnt || lapVal !== e.lapv || status !== e.st ||
        countEn !== wantCe || done !== e.dn || wrap !== e.wr) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: got count=%0d lap=%0d st=%b ce=%b done=%b wrap=%b, want count=%0d lap=%0d st=%b ce=%b done=%b wrap=%b",
               e.name, cyc, count, lapVal, status, countEn, done, wrap,
               e.cnt, e.lapv, e.st, wantCe, e.dn, e.wr);
    end
  endtask

  // Expectation describes outputs after the next rising edge; then wait for it.
  task automatic applyStimulus(input string name, input logic [7:0] cnt, input logic [7:0] lapv,
                               input logic [1:0] st, input logic dn, input logic wr);
    exp_t e;
    e.cyc = cyc + 1; e.name = name; e.cnt = cnt; e.lapv = lapv;
    e.st = st; e.dn = dn; e.wr = wr;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    exp_t r;
    start = 0; stop = 0; clear = 0; lap = 0; mode = 0; loadVal = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    applyStimulus("reset_idle", 8'd0, 8'd0, 2'b00, 1'b0, 1'b0);

    // Up count: first step four edges after entering RUNNING.
    start = 1; mode = 0;
    applyStimulus("t1_enter", 8'd0, 8'd0, 2'b01, 1'b0, 1'b0);
    start = 0;
    for (int i = 1; i <= 12; i++)
      applyStimulus("t1_count", 8'(i / 4), 8'd0, 2'b01, 1'b0, 1'b0);

    // Continue to the 255 -> 0 wrap; m counts edges after count reached 3.
    repeat (1007) @(negedge clk);
    for (int m = 1008; m <= 1013; m++)
      applyStimulus("t2_wrap", 8'((3 + m / 4) % 256), 8'd0, 2'b01, 1'b0, (m == 1012));

    repeat (20) @(negedge clk);
    lap = 1;
    applyStimulus("t6_lap_run", 8'd5, 8'd5, 2'b01, 1'b0, 1'b0);
    lap = 0;

    // Pause with prescaler phase 2, hold, then resume: step lands two edges later.
    repeat (3) @(negedge clk);
    stop = 1;
    applyStimulus("t4_pause", 8'd6, 8'd5, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      start = (i >= 5);
      applyStimulus("t4_hold", 8'd6, 8'd5, 2'b10, 1'b0, 1'b0);
    end
    stop = 0; start = 1;
    applyStimulus("t4_resume", 8'd6, 8'd5, 2'b01, 1'b0, 1'b0);
    start = 0;
    applyStimulus("t4_resume1", 8'd6, 8'd5, 2'b01, 1'b0, 1'b0);
    applyStimulus("t4_step", 8'd7, 8'd5, 2'b01, 1'b0, 1'b0);

    start = 1; stop = 1;
    applyStimulus("t5_startstop", 8'd7, 8'd5, 2'b10, 1'b0, 1'b0);
    stop = 0; clear = 1;
    applyStimulus("t5_clear", 8'd0, 8'd0, 2'b00, 1'b0, 1'b0);
    clear = 0; start = 0;
    lap = 1;
    applyStimulus("t6_lap_idle", 8'd0, 8'd0, 2'b00, 1'b0, 1'b0);
    lap = 0;

    // Countdown from 3 with a lap at count 2, then expiry and restart from DONE.
    mode = 1; loadVal = 8'd3; start = 1;
    applyStimulus("t3_load", 8'd3, 8'd0, 2'b01, 1'b0, 1'b0);
    start = 0; mode = 0;
    for (int i = 1; i <= 12; i++) begin
      lap = (i == 5);
      applyStimulus("t3_down", 8'(3 - i / 4), (i >= 5) ? 8'd2 : 8'd0,
                    (i == 12) ? 2'b11 : 2'b01, (i == 12), 1'b0);
    end
    lap = 1;
    applyStimulus("t3_done_hold", 8'd0, 8'd2, 2'b11, 1'b0, 1'b0);
    lap = 0; loadVal = 8'd5; start = 1;
    applyStimulus("t3_restart", 8'd5, 8'd2, 2'b01, 1'b0, 1'b0);
    start = 0;
    for (int i = 1; i <= 4; i++)
      applyStimulus("t3_restart_cnt", (i == 4) ? 8'd4 : 8'd5, 8'd2, 2'b01, 1'b0, 1'b0);

    // Zero load value in down mode expires immediately.
    clear = 1;
    applyStimulus("zero_clear", 8'd0, 8'd0, 2'b00, 1'b0, 1'b0);
    clear = 0; mode = 1; loadVal = 8'd0; start = 1;
    applyStimulus("zero_done", 8'd0, 8'd0, 2'b11, 1'b1, 1'b0);
    start = 0;
    applyStimulus("zero_done_after", 8'd0, 8'd0, 2'b11, 1'b0, 1'b0);
    start = 1;
    applyStimulus("zero_restart", 8'd0, 8'd0, 2'b11, 1'b1, 1'b0);
    start = 0;

    // Asynchronous reset between clock edges while running with a lap stored.
    clear = 1;
    applyStimulus("pre_rst_clear", 8'd0, 8'd0, 2'b00, 1'b0, 1'b0);
    clear = 0; mode = 0; start = 1;
    applyStimulus("rst_run", 8'd0, 8'd0, 2'b01, 1'b0, 1'b0);
    start = 0;
    repeat (4) @(negedge clk);
    lap = 1;
    applyStimulus("rst_lap", 8'd1, 8'd1, 2'b01, 1'b0, 1'b0);
    lap = 0;
    #2 rst = 1;
    #1;
    r.cyc = cyc; r.name = "async_rst"; r.cnt = 8'd0; r.lapv = 8'd0;
    r.st = 2'b00; r.dn = 1'b0; r.wr = 1'b0;
    checkOutput(r);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      vectors++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
